uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 121 ++++++++++++
 tb/tb_uart_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver oversampled by i_clk; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter logic [7:0] IDLE_DATA = 8'hFF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_done,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n, data_n;
  logic rx_m, rx_s, done_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic pbad, pbad_n, perr_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    done_n = 1'b0;
    ferr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n = pbad;
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_n = '0;
        shift_n[idx] = rx_s;
        idx_n = idx + 1'b1;
`ifdef UART_RX_PARITY_EN
        state_n = &idx ? PARITY : DATA;
`else
        state_n = &idx ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == LAST) begin
        cnt_n = '0;
        pbad_n = ^shift ^ rx_s;
        state_n = STOP;
      end
`endif
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        state_n = IDLE;
        ferr_n = !rx_s;
`ifdef UART_RX_PARITY_EN
        perr_n = rx_s && pbad;
        done_n = rx_s && !pbad;
`else
        done_n = rx_s;
`endif
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
    data_n = done_n ? shift : o_data;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_data <= IDLE_DATA;
      o_done <= 1'b0;
      o_busy <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      rx_m <= i_rx;
      rx_s <= rx_m;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      o_data <= data_n;
      o_done <= done_n;
      o_busy <= state_n != IDLE;
      o_frame_err <= ferr_n;
    end
  end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pbad <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      pbad <= pbad_n;
      o_parity_err <= perr_n;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;
  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 10;
`else
  localparam int FB = 9;
`endif
  localparam int LAT = 2 + (C - 1) / 2 + FB * C + 1;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] o_data, exp_data;
  logic o_done, o_busy, o_frame_err, o_parity_err, busy_mid;
  int checks = 0, errors = 0, cyc = 0, n_done = 0, n_ferr = 0, n_perr = 0, t0;
  int done_cyc[$];
  uart_rx #(.CLKS_PER_BIT(C), .IDLE_DATA(8'hFF)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx(rx),
    .o_data(o_data),
    .o_done(o_done),
    .o_busy(o_busy),
    .o_frame_err(o_frame_err),
    .o_parity_err(o_parity_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_done) begin
      n_done++;
      done_cyc.push_back(cyc);
    end
    if (o_frame_err) n_ferr++;
    if (o_parity_err) n_perr++;
  end
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask
  task automatic send_frame(logic [7:0] b, logic stop_ok, logic par_ok);
    t0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) busy_mid = o_busy;
      send_bit(b[i]);
    end
`ifdef UART_RX_PARITY_EN
    send_bit(par_ok ? ^b : ~^b);
`endif
    send_bit(stop_ok);
    rx = 1'b1;
  endtask
  task automatic clear_counts();
    n_done = 0;
    n_ferr = 0;
    n_perr = 0;
  endtask
  task automatic expect_frame(string tag, logic [7:0] b, logic stop_ok, logic par_ok);
    logic good;
    good = stop_ok && par_ok;
    check({tag, "_done"}, n_done, int'(good));
    check({tag, "_frame_err"}, n_ferr, int'(!stop_ok));
    check({tag, "_parity_err"}, n_perr, int'(stop_ok && !par_ok));
    if (good) exp_data = b;
    check({tag, "_data"}, o_data, exp_data);
    clear_counts();
  endtask
  initial begin
    int d;
    logic [7:0] b;
    logic s_ok, p_ok;
    exp_data = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data", o_data, 8'hFF);
    check("rst_done", o_done, 0);
    check("rst_busy", o_busy, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_parity_err", o_parity_err, 0);
    idle(5);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3 * C);
    check("glitch_done", n_done, 0);
    check("glitch_frame_err", n_ferr, 0);
    check("glitch_busy", o_busy, 0);
    check("glitch_data", o_data, 8'hFF);
    clear_counts();
    done_cyc.delete();
    send_frame(8'h02, 1'b1, 1'b1);
    check("first_busy_mid", busy_mid, 1);
    expect_frame("first", 8'h02, 1'b1, 1'b1);
    d = done_cyc.size() > 0 ? done_cyc[0] - t0 : -1;
    check("first_latency", (d >= LAT - 1 && d <= LAT + 1) ? LAT : d, LAT);
    idle(7);
    done_cyc.delete();
    send_frame(8'h05, 1'b1, 1'b1);
    expect_frame("b2b_a", 8'h05, 1'b1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    expect_frame("b2b_b", 8'h03, 1'b1, 1'b1);
    check("b2b_pulses", done_cyc.size(), 2);
    if (done_cyc.size() == 2) check("b2b_gap", done_cyc[1] - done_cyc[0], (FB + 1) * C);
    idle(3);
    send_frame(8'h06, 1'b0, 1'b1);
    expect_frame("stop_low", 8'h06, 1'b0, 1'b1);
    idle(C);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h02, 1'b1, 1'b1);
    expect_frame("par_good", 8'h02, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    expect_frame("par_bad", 8'h07, 1'b1, 1'b0);
    idle(2);
`endif
    rx = 1'b0;
    repeat (40 * C) @(negedge clk);
    check("break_frame_err", (n_ferr >= 3 && n_ferr <= 5) ? 4 : n_ferr, 4);
    check("break_done", n_done, 0);
    check("break_data", o_data, exp_data);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = 8'hFF;
    idle(2 * C);
    clear_counts();
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", o_busy, 0);
    idle(2 * C);
    check("midrst_data", o_data, 8'hFF);
    check("midrst_done", n_done, 0);
    check("midrst_frame_err", n_ferr, 0);
    clear_counts();
    send_frame(8'h06, 1'b1, 1'b1);
    expect_frame("after_rst", 8'h06, 1'b1, 1'b1);
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      s_ok = $urandom_range(0, 4) != 0;
`ifdef UART_RX_PARITY_EN
      p_ok = $urandom_range(0, 3) != 0;
`else
      p_ok = 1'b1;
`endif
      send_frame(b, s_ok, p_ok);
      expect_frame("rand", b, s_ok, p_ok);
      idle(s_ok ? $urandom_range(0, 5) : C);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
